sc_driver: RTL

- Initiator for the scircuit start/done interface.
- Accepts operand jobs (A, B, C, D, m) from a host through a valid/ready port and buffers them in a small FIFO.
- Issues the jobs one at a time to scircuit over start/done, captures R/error, and presents each result to the host through a valid/ready response port.
- Adds a done-timeout so a hung target cannot stall the host.

---
 rtl/sc_driver_pkg.sv | 23 ++
 rtl/sc_cmd_fifo.sv | 66 ++++++
 rtl/sc_driver.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sc_driver_pkg.sv
// -----------------------------------------------------------------------------
// sc_driver_pkg
//   Shared definitions for the scircuit start/done initiator:
//   - default operand width, command FIFO depth and done-timeout
//   - FSM state encodings (plain 2-bit constants)
//   - helper that sizes a packed job word {m, A, B, C, D}
// -----------------------------------------------------------------------------
package sc_driver_pkg;

  localparam int SC_W_DEFAULT       = 8;
  localparam int SC_DEPTH_DEFAULT   = 4;
  localparam int SC_TIMEOUT_DEFAULT = 64;

  localparam logic [1:0] SC_IDLE    = 2'd0;
  localparam logic [1:0] SC_ISSUE   = 2'd1;
  localparam logic [1:0] SC_RELEASE = 2'd2;

  // One job is the mode bit followed by four W-bit operands.
  function automatic int job_width(input int w);
    return 4 * w + 1;
  endfunction

endpackage

// File: rtl/sc_cmd_fifo.sv
// -----------------------------------------------------------------------------
// sc_cmd_fifo
//   Synchronous FIFO holding packed jobs {m, A, B, C, D}.
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous, active-low reset (empties the FIFO)
//     push       write push_data when not full (ignored while full)
//     push_data  job word to store
//     pop        drop the head entry when not empty
//     pop_data   current head entry (valid while !empty)
//     full       no free entry
//     empty      no stored entry
//   DEPTH must be a power of two >= 2. Pointers carry one extra wrap bit so
//   full and empty are distinguishable when the index bits match.
// -----------------------------------------------------------------------------
module sc_cmd_fifo
  import sc_driver_pkg::*;
#(
  parameter int WIDTH = job_width(SC_W_DEFAULT),
  parameter int DEPTH = SC_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are meaningful, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sc_driver.sv
// -----------------------------------------------------------------------------
// sc_driver
//   Initiator for the scircuit start/done interface. Host jobs arrive on a
//   valid/ready command port, are queued in sc_cmd_fifo, issued one at a time
//   over start/done, and each result is returned on a single-entry
//   valid/ready response port. A done-timeout keeps a hung target from
//   stalling the host.
//   Ports:
//     clk, reset               clock (rising edge) / async active-low reset
//     cmd_valid, cmd_ready     host job handshake (cmd_ready = FIFO not full)
//     cmd_m, cmd_a..cmd_d      job mode and operands
//     sc_start                 start request to scircuit
//     sc_m, sc_a..sc_d         registered mode/operands, stable for the job
//     sc_r, sc_error, sc_done  scircuit result, error flag, done
//     rsp_valid, rsp_ready     result handshake toward the host
//     rsp_r, rsp_error         captured result and error flag
//     rsp_timeout              job ended by timeout instead of done
//     busy                     FSM not idle
//     job_count                completed jobs, wraps at 8 bits
// -----------------------------------------------------------------------------
module sc_driver
  import sc_driver_pkg::*;
#(
  parameter int W       = SC_W_DEFAULT,
  parameter int DEPTH   = SC_DEPTH_DEFAULT,
  parameter int TIMEOUT = SC_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_m,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [W-1:0] cmd_c,
  input  logic [W-1:0] cmd_d,
  output logic         sc_start,
  output logic         sc_m,
  output logic [W-1:0] sc_a,
  output logic [W-1:0] sc_b,
  output logic [W-1:0] sc_c,
  output logic [W-1:0] sc_d,
  input  logic [W-1:0] sc_r,
  input  logic         sc_error,
  input  logic         sc_done,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_r,
  output logic         rsp_error,
  output logic         rsp_timeout,
  output logic         busy,
  output logic [7:0]   job_count
);

  localparam int              JW         = job_width(W);
  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [JW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          issue;

  // IDLE looks at the registered rsp_valid, so a result accepted on this edge
  // lets the next job issue one cycle later, never on the same edge.
  assign issue     = (state == SC_IDLE) && !fifo_empty && !rsp_valid;
  assign cmd_ready = !fifo_full;
  assign busy      = (state != SC_IDLE);

  sc_cmd_fifo #(
    .WIDTH (JW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data ({cmd_m, cmd_a, cmd_b, cmd_c, cmd_d}),
    .pop       (issue),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SC_IDLE;
      timer       <= '0;
      sc_start    <= 1'b0;
      sc_m        <= 1'b0;
      sc_a        <= '0;
      sc_b        <= '0;
      sc_c        <= '0;
      sc_d        <= '0;
      rsp_valid   <= 1'b0;
      rsp_r       <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      job_count   <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        SC_IDLE: begin
          // A done seen here is spurious and deliberately ignored.
          if (issue) begin
            {sc_m, sc_a, sc_b, sc_c, sc_d} <= head;
            sc_start <= 1'b1;
            timer    <= '0;
            state    <= SC_ISSUE;
          end
        end

        SC_ISSUE: begin
          timer <= timer + 1'b1;
          // done takes priority over a timeout expiring on the same edge.
          if (sc_done) begin
            rsp_r       <= sc_r;
            rsp_error   <= sc_error;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            sc_start    <= 1'b0;
            job_count   <= job_count + 1'b1;
            timer       <= '0;
            state       <= SC_RELEASE;
          end else if (timer == TIMER_LAST) begin
            rsp_r       <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            sc_start    <= 1'b0;
            job_count   <= job_count + 1'b1;
            timer       <= '0;
            state       <= SC_RELEASE;
          end
        end

        SC_RELEASE: begin
          // Wait for the target to drop done so the next start is seen as a
          // fresh request; bounded so a stuck done cannot wedge the queue.
          timer <= timer + 1'b1;
          if (!sc_done || timer == TIMER_LAST) begin
            timer <= '0;
            state <= SC_IDLE;
          end
        end

        default: begin
          state <= SC_IDLE;
        end
      endcase
    end
  end

endmodule
